cpu_mmio_router: RTL and testbench

Parametrised memory-request router between the custom CPU data port and its downstream targets: a default memory path toward the memory interface wrapper, and `N_DEV` simple MMIO device slots, such as the UART model, timers and GPIO. It generalises the single hard-wired UART tap into a decoded, registered device fabric. It owns the read-return mux and one-outstanding-transaction ordering, and returns a defined error word for unmapped slots.

---
 rtl/mmio_pkg.sv | 37 +++
 rtl/mmio_rsp_mux.sv | 34 +++
 rtl/cpu_mmio_router.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_mmio_router.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU MMIO router: FSM states, default window
// and error constants, well-known device slot numbers and sizing helpers.
// The optional watchdog is enabled by MMIO_ROUTER_TIMEOUT_EN.
package mmio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_DEV_REQ,
    ST_DEV_RSP,
    ST_ERR_RSP,
    ST_RET
  } state_t;

  localparam logic [15:0] MMIO_HI_DEFAULT  = 16'h6000;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int SLOT_UART  = 0;
  localparam int SLOT_TIMER = 1;
  localparam int SLOT_GPIO  = 2;
  localparam int SLOT_SPARE = 3;

  // Device index width, never narrower than one bit.
  function automatic int sel_width(input int n_dev);
    return (n_dev <= 2) ? 1 : $clog2(n_dev);
  endfunction

  // Watchdog counter width, clamped to 8..16 bits.
  function automatic int timeout_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mmio_rsp_mux.sv
// Read-return mux: picks the read-data slice and read strobe of the
// device slot selected by idx. Out-of-range indices return zeros.
module mmio_rsp_mux
  import mmio_pkg::*;
#(
  parameter int N_DEV = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic [32*N_DEV-1:0] dev_rdata,
  input  logic [N_DEV-1:0]    dev_rvalid,
  output logic [31:0]         rdata,
  output logic                rvalid
);

  logic [N_DEV-1:0] hit;

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_hit
    assign hit[gi] = (idx == SEL_W'(gi));
  end

  // Select the slice belonging to the one slot that matches idx.
  always_comb begin
    rdata  = '0;
    rvalid = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (hit[i]) begin
        rdata  = dev_rdata[32*i +: 32];
        rvalid = dev_rvalid[i];
      end
    end
  end

endmodule

// File: rtl/cpu_mmio_router.sv
// Routes CPU data-port requests either to the memory wrapper (pass-through)
// or to one of N_DEV registered MMIO device slots, one transaction at a time.
// Unmapped reads return ERR_DATA; unmapped writes are acknowledged and dropped.
// A slot is mapped only when the whole Address[15:SEL_LSB] field is below N_DEV,
// so stray high select bits cannot alias onto a real device.
// Define MMIO_ROUTER_TIMEOUT_EN to add the device watchdog and timeout_flag.
module cpu_mmio_router
  import mmio_pkg::*;
#(
  parameter int          N_DEV          = 4,
  parameter logic [15:0] MMIO_HI        = MMIO_HI_DEFAULT,
  parameter int          SEL_LSB        = 8,
  parameter int          OFF_W          = 8,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                cpu_clk,
  input  logic                cpu_reset_n,
  // CPU side
  input  logic [31:0]         Address,
  input  logic                MemWrite,
  input  logic [31:0]         Write_data,
  input  logic [3:0]          Write_strb,
  input  logic                MemRead,
  input  logic                Read_data_Ready,
  output logic                Mem_Req_Ready,
  output logic [31:0]         Read_data,
  output logic                Read_data_Valid,
  // Memory wrapper side
  output logic [31:0]         m_Address,
  output logic                m_MemWrite,
  output logic [31:0]         m_Write_data,
  output logic [3:0]          m_Write_strb,
  output logic                m_MemRead,
  output logic                m_Read_data_Ready,
  input  logic                m_Mem_Req_Ready,
  input  logic [31:0]         m_Read_data,
  input  logic                m_Read_data_Valid,
  // Device fabric
  output logic [N_DEV-1:0]    dev_req_valid,
  output logic                dev_we,
  output logic [OFF_W-1:0]    dev_off,
  output logic [31:0]         dev_wdata,
  output logic [3:0]          dev_wstrb,
  input  logic [N_DEV-1:0]    dev_req_ready,
  input  logic [32*N_DEV-1:0] dev_rdata,
  input  logic [N_DEV-1:0]    dev_rvalid
`ifdef MMIO_ROUTER_TIMEOUT_EN
  ,
  output logic                timeout_flag
`endif
);

  localparam int SEL_W  = sel_width(N_DEV);
  localparam int SEL_FW = 16 - SEL_LSB;
  localparam logic [SEL_FW-1:0] N_DEV_SEL = SEL_FW'(N_DEV);

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [SEL_W-1:0]  idx_reg;
  logic [31:0]       rdata_reg;

  logic              req_valid, is_mmio, is_mapped, capture_req;
  logic              sel_ready, sel_rvalid, timeout_fire;
  logic [31:0]       sel_rdata;

  assign req_valid = MemRead | MemWrite;
  assign is_mmio   = (Address[31:16] == MMIO_HI);
  assign is_mapped = (Address[15:SEL_LSB] < N_DEV_SEL);

  // Address, data and strobes are shared with the memory path; only the
  // valids are gated by the FSM.
  assign m_Address    = Address;
  assign m_Write_data = Write_data;
  assign m_Write_strb = Write_strb;

  // Device request fields come from the copies taken in IDLE.
  assign dev_we    = we_reg;
  assign dev_off   = off_reg;
  assign dev_wdata = wdata_reg;
  assign dev_wstrb = wstrb_reg;

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_req
    assign dev_req_valid[gi] = (state_reg == ST_DEV_REQ) && (idx_reg == SEL_W'(gi));
  end

  assign sel_ready = |(dev_req_valid & dev_req_ready);

  mmio_rsp_mux #(
    .N_DEV (N_DEV),
    .SEL_W (SEL_W)
  ) u_rsp_mux (
    .idx        (idx_reg),
    .dev_rdata  (dev_rdata),
    .dev_rvalid (dev_rvalid),
    .rdata      (sel_rdata),
    .rvalid     (sel_rvalid)
  );

`ifdef MMIO_ROUTER_TIMEOUT_EN
  localparam int TO_W = timeout_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_flag_reg;
  logic            in_wait;

  assign in_wait      = (state_reg == ST_DEV_REQ) || (state_reg == ST_DEV_RSP);
  assign timeout_fire = in_wait && (to_cnt_reg == TO_LAST) &&
                        !((state_reg == ST_DEV_REQ) && sel_ready) &&
                        !((state_reg == ST_DEV_RSP) && sel_rvalid);
  assign timeout_flag = timeout_flag_reg;

  // Count cycles spent waiting on a device; restart on every state change.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      to_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      if (state_next != state_reg) to_cnt_reg <= '0;
      else if (in_wait)            to_cnt_reg <= to_cnt_reg + 1'b1;
      if (timeout_fire)            timeout_flag_reg <= 1'b1;
    end
  end
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_fire = 1'b0;
`endif

  // State register, request capture and read-return word.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      off_reg   <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      idx_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture_req) begin
        we_reg    <= MemWrite;
        off_reg   <= Address[OFF_W-1:0];
        wdata_reg <= Write_data;
        wstrb_reg <= Write_strb;
        idx_reg   <= Address[SEL_LSB +: SEL_W];
      end
      if ((state_reg == ST_DEV_RSP) && sel_rvalid) rdata_reg <= sel_rdata;
      else if (state_reg == ST_ERR_RSP)            rdata_reg <= ERR_DATA;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next        = state_reg;
    capture_req       = 1'b0;
    Mem_Req_Ready     = 1'b0;
    Read_data         = '0;
    Read_data_Valid   = 1'b0;
    m_MemRead         = 1'b0;
    m_MemWrite        = 1'b0;
    m_Read_data_Ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (!is_mmio) begin
            m_MemWrite    = MemWrite;
            m_MemRead     = MemRead & ~MemWrite;
            Mem_Req_Ready = m_Mem_Req_Ready;
            if (m_Mem_Req_Ready && !MemWrite) state_next = ST_MEM_RD;
          end else begin
            capture_req = 1'b1;
            if (is_mapped) begin
              state_next = ST_DEV_REQ;
            end else begin
              Mem_Req_Ready = 1'b1;
              if (!MemWrite) state_next = ST_ERR_RSP;
            end
          end
        end
      end
      ST_MEM_RD: begin
        Read_data         = m_Read_data;
        Read_data_Valid   = m_Read_data_Valid;
        m_Read_data_Ready = Read_data_Ready;
        if (m_Read_data_Valid && Read_data_Ready) state_next = ST_IDLE;
      end
      ST_DEV_REQ: begin
        if (sel_ready) begin
          Mem_Req_Ready = 1'b1;
          state_next    = we_reg ? ST_IDLE : ST_DEV_RSP;
        end else if (timeout_fire) begin
          Mem_Req_Ready = we_reg;
          state_next    = we_reg ? ST_IDLE : ST_ERR_RSP;
        end
      end
      ST_DEV_RSP: begin
        if (sel_rvalid)        state_next = ST_RET;
        else if (timeout_fire) state_next = ST_ERR_RSP;
      end
      ST_ERR_RSP: state_next = ST_RET;
      ST_RET: begin
        Read_data       = rdata_reg;
        Read_data_Valid = 1'b1;
        if (Read_data_Ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_mmio_router.sv
// Directed bench for cpu_mmio_router: a table of IDLE-state decode vectors
// followed by hand-written device, error, memory, timeout and reset sequences.
// The timeout sequence is included when MMIO_ROUTER_TIMEOUT_EN is defined.
module tb_cpu_mmio_router;
  import mmio_pkg::*;

  localparam int N_DEV = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_reset_n;
  logic [31:0]   Address, Write_data;
  logic          MemWrite, MemRead, Read_data_Ready;
  logic [3:0]    Write_strb;
  logic          Mem_Req_Ready, Read_data_Valid;
  logic [31:0]   Read_data;
  logic [31:0]   m_Address, m_Write_data, m_Read_data;
  logic          m_MemWrite, m_MemRead, m_Read_data_Ready;
  logic [3:0]    m_Write_strb;
  logic          m_Mem_Req_Ready, m_Read_data_Valid;
  logic [N_DEV-1:0]    dev_req_valid, dev_req_ready, dev_rvalid;
  logic                dev_we;
  logic [7:0]          dev_off;
  logic [31:0]         dev_wdata;
  logic [3:0]          dev_wstrb;
  logic [32*N_DEV-1:0] dev_rdata;
`ifdef MMIO_ROUTER_TIMEOUT_EN
  logic          timeout_flag;
`endif

  always #5 cpu_clk = ~cpu_clk;

  cpu_mmio_router #(
    .N_DEV          (N_DEV),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .cpu_clk           (cpu_clk),
    .cpu_reset_n       (cpu_reset_n),
    .Address           (Address),
    .MemWrite          (MemWrite),
    .Write_data        (Write_data),
    .Write_strb        (Write_strb),
    .MemRead           (MemRead),
    .Read_data_Ready   (Read_data_Ready),
    .Mem_Req_Ready     (Mem_Req_Ready),
    .Read_data         (Read_data),
    .Read_data_Valid   (Read_data_Valid),
    .m_Address         (m_Address),
    .m_MemWrite        (m_MemWrite),
    .m_Write_data      (m_Write_data),
    .m_Write_strb      (m_Write_strb),
    .m_MemRead         (m_MemRead),
    .m_Read_data_Ready (m_Read_data_Ready),
    .m_Mem_Req_Ready   (m_Mem_Req_Ready),
    .m_Read_data       (m_Read_data),
    .m_Read_data_Valid (m_Read_data_Valid),
    .dev_req_valid     (dev_req_valid),
    .dev_we            (dev_we),
    .dev_off           (dev_off),
    .dev_wdata         (dev_wdata),
    .dev_wstrb         (dev_wstrb),
    .dev_req_ready     (dev_req_ready),
    .dev_rdata         (dev_rdata),
    .dev_rvalid        (dev_rvalid)
`ifdef MMIO_ROUTER_TIMEOUT_EN
    ,
    .timeout_flag      (timeout_flag)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic        m_rdy;
    logic        exp_m_rd;
    logic        exp_m_wr;
    logic        exp_ready;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int vcnt, pcnt, other, early, held, got;
  logic [N_DEV-1:0] act_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{"mem_rd_ready",   32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"mem_rd_stall",   32'h0000_1004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"mem_wr",         32'h0000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"mem_rd_and_wr",  32'h0000_3000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"no_request",     32'h0000_4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"mmio_mapped_rd", 32'h6000_0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"mmio_mapped_wr", 32'h6000_0200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"mmio_unmap_wr",  32'h6000_0400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"mmio_unmap_rd",  32'h6000_FF00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{"above_window",   32'h6001_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    Address = '0; MemWrite = 0; MemRead = 0; Write_data = '0; Write_strb = '0;
    Read_data_Ready = 0; m_Mem_Req_Ready = 0; m_Read_data = '0; m_Read_data_Valid = 0;
    dev_req_ready = '0; dev_rvalid = '0; dev_rdata = '0;
    cpu_reset_n = 0;

    // Reset state
    repeat (2) @(negedge cpu_clk);
    #1;
    chk("rst_mem_req_ready", 32'(Mem_Req_Ready), 32'h0);
    chk("rst_rd_valid",      32'(Read_data_Valid), 32'h0);
    chk("rst_rd_data",       Read_data, 32'h0);
    chk("rst_dev_req_valid", 32'(dev_req_valid), 32'h0);
    chk("rst_m_memread",     32'(m_MemRead), 32'h0);
    chk("rst_m_memwrite",    32'(m_MemWrite), 32'h0);
    @(negedge cpu_clk);
    cpu_reset_n = 1;

    // IDLE decode table; requests are withdrawn before the clock edge
    for (int i = 0; i < NV; i++) begin
      @(negedge cpu_clk);
      Address = vecs[i].addr; MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
      m_Mem_Req_Ready = vecs[i].m_rdy;
      #1;
      chk({vecs[i].name, "_m_rd"},    32'(m_MemRead), 32'(vecs[i].exp_m_rd));
      chk({vecs[i].name, "_m_wr"},    32'(m_MemWrite), 32'(vecs[i].exp_m_wr));
      chk({vecs[i].name, "_ready"},   32'(Mem_Req_Ready), 32'(vecs[i].exp_ready));
      chk({vecs[i].name, "_dev_vld"}, 32'(dev_req_valid), 32'h0);
      chk({vecs[i].name, "_m_addr"},  m_Address, vecs[i].addr);
      MemRead = 0; MemWrite = 0; m_Mem_Req_Ready = 0;
    end

    // Write 0x41 to slot 0, device ready in the third request cycle
    @(negedge cpu_clk);
    Address = 32'h6000_0004; MemWrite = 1; Write_data = 32'h41; Write_strb = 4'hF;
    #1;
    chk("wr_idle_no_ready", 32'(Mem_Req_Ready), 32'h0);
    vcnt = 0; pcnt = 0; other = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge cpu_clk);
      dev_req_ready = (k == 2) ? 4'b0001 : 4'b0000;
      #1;
      if (k == 0) begin
        chk("wr_dev_off",   32'(dev_off), 32'h04);
        chk("wr_dev_wdata", dev_wdata, 32'h41);
        chk("wr_dev_we",    32'(dev_we), 32'h1);
        chk("wr_dev_wstrb", 32'(dev_wstrb), 32'hF);
      end
      if (dev_req_valid[0]) vcnt++;
      if (dev_req_valid[3:1] != 3'b000) other++;
      if (Mem_Req_Ready) begin
        pcnt++;
        MemWrite = 0;
      end
    end
    dev_req_ready = '0;
    chk("wr_valid_cycles", 32'(vcnt), 32'd3);
    chk("wr_ready_pulses", 32'(pcnt), 32'd1);
    chk("wr_other_slots",  32'(other), 32'd0);

    // Read slot 1, data five cycles after accept, CPU stalls four cycles
    @(negedge cpu_clk);
    Address = 32'h6000_0108; MemRead = 1;
    #1;
    chk("rd_idle_no_ready", 32'(Mem_Req_Ready), 32'h0);
    @(negedge cpu_clk);
    dev_req_ready = 4'b0010;
    #1;
    chk("rd_dev_req_valid", 32'(dev_req_valid), 32'h2);
    chk("rd_accept",        32'(Mem_Req_Ready), 32'h1);
    chk("rd_dev_off",       32'(dev_off), 32'h08);
    chk("rd_dev_we",        32'(dev_we), 32'h0);
    MemRead = 0;
    early = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge cpu_clk);
      dev_req_ready = '0;
      if (k == 5) begin
        dev_rvalid = 4'b0010;
        dev_rdata  = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0000};
      end
      #1;
      if (Read_data_Valid) early++;
    end
    chk("rd_no_early_valid", 32'(early), 32'd0);
    @(negedge cpu_clk);
    dev_rvalid = '0; dev_rdata = '1;
    #1;
    chk("rd_valid",   32'(Read_data_Valid), 32'h1);
    chk("rd_data",    Read_data, 32'h1234_5678);
    held = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge cpu_clk);
      #1;
      if (Read_data_Valid && Read_data == 32'h1234_5678) held++;
    end
    chk("rd_held_cycles", 32'(held), 32'd4);
    @(negedge cpu_clk);
    Read_data_Ready = 1;
    #1;
    chk("rd_handshake_valid", 32'(Read_data_Valid), 32'h1);
    @(negedge cpu_clk);
    Read_data_Ready = 0;
    #1;
    chk("rd_after_valid", 32'(Read_data_Valid), 32'h0);

    // Unmapped read of 0x6000_0F00
    @(negedge cpu_clk);
    Address = 32'h6000_0F00; MemRead = 1;
    #1;
    chk("unmap_ready_pulse", 32'(Mem_Req_Ready), 32'h1);
    act_seen = dev_req_valid;
    @(negedge cpu_clk);
    MemRead = 0;
    #1;
    act_seen |= dev_req_valid;
    chk("unmap_err_cycle_valid", 32'(Read_data_Valid), 32'h0);
    @(negedge cpu_clk);
    #1;
    act_seen |= dev_req_valid;
    chk("unmap_valid", 32'(Read_data_Valid), 32'h1);
    chk("unmap_data",  Read_data, 32'hDEAD_BEEF);
    Read_data_Ready = 1;
    @(negedge cpu_clk);
    Read_data_Ready = 0;
    #1;
    act_seen |= dev_req_valid;
    chk("unmap_done",        32'(Read_data_Valid), 32'h0);
    chk("unmap_no_dev_vld",  32'(act_seen), 32'h0);

    // Memory read with a stray device strobe on slot 2
    @(negedge cpu_clk);
    Address = 32'h0000_1000; MemRead = 1; m_Mem_Req_Ready = 1;
    #1;
    chk("mem_m_rd",   32'(m_MemRead), 32'h1);
    chk("mem_accept", 32'(Mem_Req_Ready), 32'h1);
    @(negedge cpu_clk);
    m_Mem_Req_Ready = 1; Read_data_Ready = 1;
    dev_rvalid = 4'b0100; dev_rdata = {32'h0, 32'h0BAD_0BAD, 64'h0};
    #1;
    chk("mem_busy_m_rd_gated",  32'(m_MemRead), 32'h0);
    chk("mem_busy_no_ready",    32'(Mem_Req_Ready), 32'h0);
    chk("mem_wait_valid",       32'(Read_data_Valid), 32'h0);
    chk("mem_rdy_passthru",     32'(m_Read_data_Ready), 32'h1);
    MemRead = 0; m_Mem_Req_Ready = 0;
    @(negedge cpu_clk);
    dev_rvalid = '0; m_Read_data = 32'hCAFE_F00D; m_Read_data_Valid = 1;
    #1;
    chk("mem_valid", 32'(Read_data_Valid), 32'h1);
    chk("mem_data",  Read_data, 32'hCAFE_F00D);
    @(negedge cpu_clk);
    m_Read_data_Valid = 0; Read_data_Ready = 0;
    #1;
    chk("mem_done_valid", 32'(Read_data_Valid), 32'h0);
    chk("mem_done_data",  Read_data, 32'h0);

`ifdef MMIO_ROUTER_TIMEOUT_EN
    // Slot 3 accepts but never responds; watchdog returns ERR_DATA
    chk("to_flag_before", 32'(timeout_flag), 32'h0);
    @(negedge cpu_clk);
    Address = 32'h6000_0300; MemRead = 1;
    @(negedge cpu_clk);
    dev_req_ready = 4'b1000;
    #1;
    chk("to_accept", 32'(Mem_Req_Ready), 32'h1);
    MemRead = 0;
    got = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge cpu_clk);
      dev_req_ready = '0;
      #1;
      if (Read_data_Valid) begin
        got = k;
        break;
      end
    end
    chk("to_latency", 32'(got), 32'd18);
    chk("to_data",    Read_data, 32'hDEAD_BEEF);
    chk("to_flag",    32'(timeout_flag), 32'h1);
    Read_data_Ready = 1;
    @(negedge cpu_clk);
    Read_data_Ready = 0;
`endif

    // Reset while waiting for slot 2 read data, then a normal read of slot 0
    @(negedge cpu_clk);
    Address = 32'h6000_0200; MemRead = 1;
    @(negedge cpu_clk);
    dev_req_ready = 4'b0100;
    #1;
    chk("rst_seq_accept", 32'(Mem_Req_Ready), 32'h1);
    MemRead = 0;
    @(negedge cpu_clk);
    dev_req_ready = '0;
    #1;
    cpu_reset_n = 0;
    #1;
    chk("midrst_dev_vld",   32'(dev_req_valid), 32'h0);
    chk("midrst_rd_valid",  32'(Read_data_Valid), 32'h0);
    chk("midrst_rd_data",   Read_data, 32'h0);
    chk("midrst_mem_ready", 32'(Mem_Req_Ready), 32'h0);
    chk("midrst_m_rd",      32'(m_MemRead), 32'h0);
`ifdef MMIO_ROUTER_TIMEOUT_EN
    chk("midrst_to_flag",   32'(timeout_flag), 32'h0);
`endif
    @(negedge cpu_clk);
    dev_rvalid = 4'b0100; dev_rdata = {32'h0, 32'h5555_5555, 64'h0};
    @(negedge cpu_clk);
    cpu_reset_n = 1;
    @(negedge cpu_clk);
    dev_rvalid = '0;
    #1;
    chk("late_rsp_ignored", 32'(Read_data_Valid), 32'h0);
    @(negedge cpu_clk);
    Address = 32'h6000_0010; MemRead = 1;
    @(negedge cpu_clk);
    dev_req_ready = 4'b0001;
    #1;
    chk("post_rst_accept", 32'(Mem_Req_Ready), 32'h1);
    MemRead = 0;
    @(negedge cpu_clk);
    dev_req_ready = '0; dev_rvalid = 4'b0001;
    dev_rdata = {96'h0, 32'hA5A5_0001};
    @(negedge cpu_clk);
    dev_rvalid = '0;
    #1;
    chk("post_rst_valid", 32'(Read_data_Valid), 32'h1);
    chk("post_rst_data",  Read_data, 32'hA5A5_0001);
    Read_data_Ready = 1;
    @(negedge cpu_clk);
    Read_data_Ready = 0;
    #1;
    chk("post_rst_done", 32'(Read_data_Valid), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
